// File: rtl/fetch_queue.sv
// RV32I instruction-fetch stage: owns the fetch PC, issues single outstanding
// word reads to instruction memory and buffers {pc, instr} pairs for decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t        state, state_n;
    logic [31:0]   fetch_pc, fetch_pc_n;
    logic [31:0]   squash_pc, squash_pc_n;
    logic [31:0]   target_pc;

    entry_t        fifo_mem [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [CW-1:0] count_push;

    logic          push, pop, pop_req, flush;

    assign target_pc  = {redirect_pc[31:2], 2'b00};
    assign pop_req    = out_valid && out_ready;
    // Occupancy after a push in this cycle, used to decide whether to keep fetching.
    assign count_push = count + CW'(1) - CW'(pop_req);

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        squash_pc_n = squash_pc;
        push        = 1'b0;
        flush       = 1'b0;
        case (state)
            IDLE: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_n = target_pc;
                end else if (count < FULL) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_n = target_pc;
                    if (imem_resp) begin
                        state_n = IDLE;
                    end else begin
                        // Request is still in flight; keep its address on the bus.
                        state_n     = DRAIN;
                        squash_pc_n = fetch_pc;
                    end
                end else if (imem_resp) begin
                    push       = 1'b1;
                    fetch_pc_n = fetch_pc + 32'd4;
                    if (count_push >= FULL) state_n = IDLE;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_n = target_pc;
                end
                if (imem_resp) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign pop = pop_req && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            squash_pc <= 32'd0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            state     <= state_n;
            fetch_pc  <= fetch_pc_n;
            squash_pc <= squash_pc_n;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + AW'(1);
                if (pop)  head <= head + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[tail] <= '{pc: fetch_pc, instr: imem_rdata};
    end

    assign imem_read    = (state == REQ) || (state == DRAIN);
    assign imem_address = (state == DRAIN) ? squash_pc : fetch_pc;

    assign out_valid = (count != '0);
    assign out_pc    = out_valid ? fifo_mem[head].pc    : 32'd0;
    assign out_instr = out_valid ? fifo_mem[head].instr : 32'd0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, all checked
// every cycle against a queue-based reference model of the fetch stage.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0060;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_read   (imem_read),
        .imem_address(imem_address),
        .imem_resp   (imem_resp),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          lat   = 0;
    int          wait_cnt = 0;
    logic [31:0] key = 32'd0;

    // Reference model: delivered-but-unconsumed instructions, next fetch PC,
    // whether a request is outstanding and whether its data will be kept.
    logic [63:0] q[$];
    logic [31:0] m_fpc;
    logic [31:0] m_paddr;
    bit          m_pend;
    bit          m_live;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [31:0] ea;
        ea = (m_pend && !m_live) ? m_paddr : m_fpc;
        chk("imem_read",    {31'd0, imem_read}, {31'd0, m_pend});
        chk("imem_address", imem_address, ea);
        chk("out_valid",    {31'd0, out_valid}, (q.size() != 0) ? 32'd1 : 32'd0);
        chk("out_pc",       out_pc,    (q.size() != 0) ? q[0][63:32] : 32'd0);
        chk("out_instr",    out_instr, (q.size() != 0) ? q[0][31:0]  : 32'd0);
    endtask

    task automatic model_step();
        int n0;
        bit pop;
        n0  = q.size();
        pop = !redirect && (n0 != 0) && out_ready;
        if (redirect) begin
            q.delete();
            if (m_pend) begin
                if (imem_resp) m_pend = 1'b0;
                else if (m_live) begin
                    m_live  = 1'b0;
                    m_paddr = m_fpc;
                end
            end
            m_fpc = {redirect_pc[31:2], 2'b00};
        end else if (m_pend) begin
            if (pop) void'(q.pop_front());
            if (imem_resp) begin
                if (m_live) begin
                    q.push_back({m_fpc, imem_rdata});
                    m_fpc  = m_fpc + 32'd4;
                    m_pend = (q.size() < DEPTH);
                end else begin
                    m_pend = 1'b0;
                end
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (n0 < DEPTH) begin
                m_pend = 1'b1;
                m_live = 1'b1;
            end
        end
    endtask

    // One clock: check outputs, drive inputs, answer memory, advance model.
    task automatic cyc(input bit rdy, input bit rd = 1'b0, input logic [31:0] rpc = 32'd0);
        check_all();
        out_ready   = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        if (imem_read && wait_cnt >= lat) begin
            imem_resp  = 1'b1;
            imem_rdata = imem_address ^ key;
            wait_cnt   = 0;
        end else begin
            imem_resp  = 1'b0;
            imem_rdata = $urandom;
            wait_cnt   = imem_read ? wait_cnt + 1 : 0;
        end
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        redirect  = 1'b0;
        imem_resp = 1'b0;
        wait_cnt  = 0;
        @(posedge clk);
        @(negedge clk);
        q.delete();
        m_fpc   = RPC;
        m_paddr = 32'd0;
        m_pend  = 1'b0;
        m_live  = 1'b0;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        int i;
        // In-order streaming, word = address, single-cycle memory
        key = 32'd0;
        lat = 0;
        do_reset();
        for (int k = 0; k < 12; k++) cyc(1'b1);

        // Decode stalled: FIFO fills, fetch stops, then one pop frees one slot
        do_reset();
        for (int k = 0; k < 10; k++) cyc(1'b0);
        chk("fill_read",  {31'd0, imem_read}, 32'd0);
        chk("fill_head",  out_pc, 32'h60);
        chk("fill_instr", out_instr, 32'h60);
        cyc(1'b1);
        for (int k = 0; k < 3; k++) cyc(1'b0);
        chk("refill_head", out_pc, 32'h64);

        // Redirect while a slow request at 0x68 is in flight
        do_reset();
        for (i = 0; i < 20 && !(imem_read && imem_address == 32'h64); i++) cyc(1'b0);
        chk("reach_64", imem_address, 32'h64);
        cyc(1'b0);
        lat = 3;
        cyc(1'b0);
        cyc(1'b1, 1'b1, 32'h200);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);
        chk("drain_addr",  imem_address, 32'h68);
        for (int k = 0; k < 6; k++) cyc(1'b0);
        lat = 0;
        for (i = 0; i < 20 && !out_valid; i++) cyc(1'b0);
        chk("redir_first_pc", out_pc, 32'h200);

        // Redirect coinciding with a response and a pop
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1);
        chk("pre_redir_valid", {31'd0, out_valid}, 32'd1);
        cyc(1'b1, 1'b1, 32'h123);
        chk("post_redir_valid", {31'd0, out_valid}, 32'd0);
        chk("post_redir_addr",  imem_address, 32'h120);
        for (int k = 0; k < 4; k++) cyc(1'b1);

        // Two redirects during DRAIN: the last one wins
        do_reset();
        lat = 3;
        cyc(1'b1);
        cyc(1'b1, 1'b1, 32'h300);
        cyc(1'b1, 1'b1, 32'h400);
        for (i = 0; i < 20 && !(imem_read && imem_address != 32'h60); i++) cyc(1'b1);
        chk("last_redir_wins", imem_address, 32'h400);
        lat = 0;

        // PC wrap, then reset in the middle of a request
        do_reset();
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
        for (i = 0; i < 10 && !(imem_read && imem_address == 32'h0); i++) cyc(1'b1);
        chk("wrap_addr", imem_address, 32'h0);
        chk("wrap_pc",   out_pc, 32'hFFFF_FFFC);
        lat = 3;
        cyc(1'b1);
        chk("mid_req_read", {31'd0, imem_read}, 32'd1);
        do_reset();
        chk("rst_read",  {31'd0, imem_read}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_addr",  imem_address, RPC);

        // Random traffic
        key = $urandom;
        for (int k = 0; k < 3000; k++) begin
            lat = $urandom_range(0, 3);
            if ($urandom_range(0, 599) == 0) do_reset();
            else cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom);
        end
        cyc(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
